// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types, constants and helpers for the BCD countdown timer
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Clamp a raw nibble to a legal BCD digit; codes A..F become 9.
    function automatic bcd_t bcd_sat(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: combinational single-digit BCD decrement with borrow chain
module bcd_digit_down
    import countdown_pkg::*;
(
    input  bcd_t digit,
    input  logic borrow_in,
    output bcd_t next,
    output logic borrow_out
);

    // A borrow into a zero digit wraps it to 9 and passes the borrow upward.
    always_comb begin
        next       = borrow_in ? ((digit == 4'd0) ? BCD_MAX : digit - 4'd1) : digit;
        borrow_out = borrow_in && (digit == 4'd0);
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable multi-digit BCD down-counter with prescaled tick and expiry pulse
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int DIGITS   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] value,
    output logic                running,
    output logic                done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t              state;
    logic [PW-1:0]       prescaler;
    logic [4*DIGITS-1:0] sat_value;
    logic [4*DIGITS-1:0] dec_value;
    logic [DIGITS:0]     borrow;

    // Saturate every incoming digit so the register only ever holds legal BCD.
    always_comb begin
        sat_value = '0;
        for (int i = 0; i < DIGITS; i++)
            sat_value[4*i +: 4] = bcd_sat(load_value[4*i +: 4]);
    end

    assign borrow[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_down u_digit (
                .digit      (value[4*g +: 4]),
                .borrow_in  (borrow[g]),
                .next       (dec_value[4*g +: 4]),
                .borrow_out (borrow[g+1])
            );
        end
    endgenerate

    // Control FSM; all outputs are registered so no input reaches an output combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            value     <= '0;
            prescaler <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                value     <= sat_value;
                prescaler <= '0;
                state     <= IDLE;
                running   <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSED: begin
                        if (start) begin
                            if (value != '0) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end else begin
                                state <= EXPIRED;
                                done  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        // Pause beats a terminal tick; the held prescaler makes the
                        // pending decrement land on the first edge after resume.
                        if (pause) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (prescaler == PRESC_LAST) begin
                            prescaler <= '0;
                            value     <= dec_value;
                            if (dec_value == '0) begin
                                state   <= EXPIRED;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer
module tb_countdown_timer;
    import countdown_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] value;
    logic       running;
    logic       done;

    int total = 0;
    int bad = 0;

    countdown_timer #(.TICK_DIV(4), .DIGITS(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .value      (value),
        .running    (running),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_value = v;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk("rst_value", 32'(value), 32'h00);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        do_load(8'h12);
        chk("load12", 32'(value), 32'h12);
        do_start();
        chk("run_running", 32'(running), 1);
        step(3);
        chk("pre_tick", 32'(value), 32'h12);
        step(1);
        chk("dec_11", 32'(value), 32'h11);
        step(4);
        chk("dec_10", 32'(value), 32'h10);
        step(4);
        chk("borrow_09", 32'(value), 32'h09);

        do_load(8'h02);
        do_start();
        step(4);
        chk("dec_01", 32'(value), 32'h01);
        chk("no_done_early", 32'(done), 0);
        step(4);
        chk("zero_value", 32'(value), 32'h00);
        chk("zero_done", 32'(done), 1);
        chk("zero_running", 32'(running), 0);
        chk("zero_state", 32'(dut.state), 32'(EXPIRED));
        step(1);
        chk("done_one_cycle", 32'(done), 0);
        do_start();
        chk("exp_start_value", 32'(value), 32'h00);
        chk("exp_start_running", 32'(running), 0);
        chk("exp_start_done", 32'(done), 0);

        do_load(8'h05);
        do_start();
        step(2);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("paused_state", 32'(dut.state), 32'(PAUSED));
        chk("paused_running", 32'(running), 0);
        step(10);
        chk("paused_hold", 32'(value), 32'h05);
        do_start();
        chk("resume_running", 32'(running), 1);
        step(1);
        chk("resume_wait", 32'(value), 32'h05);
        step(1);
        chk("resume_dec", 32'(value), 32'h04);

        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("term_pause_value", 32'(value), 32'h04);
        chk("term_pause_presc", 32'(dut.prescaler), 3);
        do_start();
        chk("term_resume_value", 32'(value), 32'h04);
        step(1);
        chk("term_resume_dec", 32'(value), 32'h03);

        load = 1'b1;
        start = 1'b1;
        load_value = 8'h37;
        step(1);
        load = 1'b0;
        start = 1'b0;
        chk("ldst_value", 32'(value), 32'h37);
        chk("ldst_state", 32'(dut.state), 32'(IDLE));
        chk("ldst_running", 32'(running), 0);

        do_load(8'hAF);
        chk("sat_99", 32'(value), 32'h99);
        do_load(8'h00);
        do_start();
        chk("zero_start_done", 32'(done), 1);
        chk("zero_start_running", 32'(running), 0);
        chk("zero_start_state", 32'(dut.state), 32'(EXPIRED));
        step(1);
        chk("zero_start_done_off", 32'(done), 0);

        do_load(8'h07);
        do_start();
        step(2);
        chk("mid_value", 32'(value), 32'h07);
        chk("mid_running", 32'(running), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("abort_value", 32'(value), 32'h00);
        chk("abort_running", 32'(running), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable multi-digit BCD down-counter with start/pause/expire control, driven from the system clock through an internal prescaler. It counts in the opposite direction to the lab's free-running up-counters. It drives the seven-segment display path and raises a one-cycle `done` pulse for buzzer/LED logic when the count reaches zero.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per count step (≥ 2).
- `DIGITS`, default 4: number of BCD digits (1–8).

Ports:
- `clock`, in, 1: system clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high global reset.
- `load`, in, 1: load `load_value` into the counter.
- `load_value`, in, 4*DIGITS: BCD start value; digit 0 in bits [3:0].
- `start`, in, 1: begin or resume counting.
- `pause`, in, 1: suspend counting.
- `value`, out, 4*DIGITS: current BCD count (registered).
- `running`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse on reaching zero.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- Reset:
  - state IDLE, `value` all zero, prescaler 0.
  - `running` = 0, `done` = 0.
- Input priority per edge: `reset` > `load` > `start` > `pause`.
- `load`, accepted in any state:
  - `value` ← `load_value`, with any digit > 9 saturated to 9.
  - prescaler ← 0, state → IDLE.
  - Any same-cycle `start` is ignored.
- `start`:
  - In IDLE or PAUSED with nonzero `value`: → RUN.
  - In IDLE or PAUSED with zero `value`: → EXPIRED, `done` pulses.
  - Ignored in RUN and EXPIRED.
- `pause` in RUN: → PAUSED, prescaler held (not cleared); ignored elsewhere.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On the edge where the prescaler equals TICK_DIV-1, `value` decrements by one in BCD. A digit at 0 becomes 9 and borrows from the next digit.
  - If the new value is zero: same edge → EXPIRED, `done` ← 1.
- `pause` coinciding with a terminal prescaler count: pause wins, no decrement, prescaler stays at TICK_DIV-1. The decrement then occurs on the first RUN edge after resume.
- EXPIRED: `value` holds zero, `start`/`pause` ignored; only `load` or `reset` leaves.
- No wrap below zero; `value` never underflows.

## Timing
- `value`, `running`, `done` are all registered; no combinational input→output paths.
- `running` rises the edge after `start` is sampled, and falls the edge after `pause`, `load` or expiry is sampled.
- First decrement occurs TICK_DIV cycles after entry to RUN from a fresh load (prescaler 0).
- `done` is high for exactly one cycle, coincident with the first cycle `value` reads zero. It deasserts on the next edge unconditionally.
- `load` takes effect on the sampling edge; the new `value` is visible the following cycle.
- A `reset` mid-count aborts on that edge: outputs read reset values next cycle.

## Structure
- Package `countdown_pkg`:
  - `state_t` enum {IDLE, RUN, PAUSED, EXPIRED}.
  - `bcd_t` (logic [3:0]).
  - Constant `BCD_MAX` = 4'd9.
  - Function `bcd_sat` (clamp a digit to 9).
- Sub-module `bcd_digit_down`:
  - Combinational single digit.
  - Inputs: digit, borrow_in. Outputs: next digit, borrow_out.
  - Instantiated DIGITS times in a generate chain.
- Top holds the FSM, prescaler (width $clog2(TICK_DIV)), value register and `done` register.

## Test plan
Bench uses TICK_DIV=4, DIGITS=2.
- Reset, then load 0x12, start → `running`=1; `value` reads 0x11 after 4 cycles, then 0x10, then 0x09 (borrow).
- Load 0x02, start, run → `value` 0x01, then 0x00 with `done`=1 for exactly one cycle; state EXPIRED. A later `start` leaves `value`=0x00, `running`=0.
- Load 0x05, start, pause at prescaler=2, hold 10 cycles → `value` stays 0x05. Start → decrement to 0x04 after 2 further cycles.
- Pause asserted on the terminal-count edge → no decrement. Load and start in the same cycle → `value`=load, state IDLE, `running`=0.
- Load 0xAF → `value` reads 0x99. Load 0x00, start → `done` pulses once, `running` stays 0.
- Reset mid-count at `value`=0x07 → next cycle `value`=0x00, `running`=0, `done`=0, state IDLE.
